// File: rtl/digit_serial_adder_pkg.sv
// Types, default widths and sizing helpers shared by the digit-serial adder,
// its bus interface and anything that instantiates it.
`include "digit_serial_adder_defs.svh"

package digit_serial_adder_pkg;

  localparam int DEF_N = `WIDTH;
  localparam int DEF_K = `DIGIT;

  typedef enum logic [1:0] {
    IDLE = `ST_IDLE,
    RUN  = `ST_RUN,
    DONE = `ST_DONE
  } state_t;

  // Digit counter width; a single-digit configuration still keeps one bit.
  function automatic int cnt_width(input int n, input int k);
    return (n / k > 1) ? $clog2(n / k) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Request/result bus between a datapath controller and the digit-serial adder.
interface digit_serial_adder_if #(
  parameter int N = digit_serial_adder_pkg::DEF_N
);

  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic [N-1:0] sum;
  logic         co;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, sub, a, b, ci,
    input  sum, co, ovf, busy, done
  );

  modport slave (
    input  start, sub, a, b, ci,
    output sum, co, ovf, busy, done
  );

endinterface

// File: rtl/digit_serial_adder_defs.svh
// Shared encodings and default widths for the digit-serial adder slice.
// Pulled in once by the package; everything else sees them through the package.
`ifndef DIGIT_SERIAL_ADDER_DEFS_SVH
`define DIGIT_SERIAL_ADDER_DEFS_SVH

`define ST_IDLE 2'd0
`define ST_RUN  2'd1
`define ST_DONE 2'd2

`define WIDTH 16
`define DIGIT 4

`endif

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational K-bit ripple full adder: one digit slice of the serial adder.
module digit_adder #(
  parameter int K = 4
) (
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout
);

  logic [K:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < K; gi++) begin : g_bit
    assign s[gi]     = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi + 1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
  end

  assign cout = c[K];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract unit: N-bit operands processed K bits per clock,
// least significant digit first, with start/busy/done handshake and overflow flag.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K
) (
  input logic               clk,
  input logic               reset,
  digit_serial_adder_if.slave bus
);

  localparam int D  = N / K;
  localparam int CW = cnt_width(N, K);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [N-1:0]  a_reg, b_reg, sum_reg;
  logic          carry_reg, co_reg, ovf_reg;

  logic          accept, step, last;
  int            digit_base;
  logic [K-1:0]  a_dig, b_dig, s_dig;
  logic          c_dig;

  always_comb begin
    digit_base = int'(cnt_reg) * K;
    a_dig      = a_reg[digit_base +: K];
    b_dig      = b_reg[digit_base +: K];
  end

  digit_adder #(.K(K)) u_digit (
    .x    (a_dig),
    .y    (b_dig),
    .cin  (carry_reg),
    .s    (s_dig),
    .cout (c_dig)
  );

  assign last = (cnt_reg == CW'(D - 1));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        step     = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~ci, so the operand is inverted once at acceptance
  // and every digit then runs through the same adder.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      co_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      cnt_reg   <= '0;
      a_reg     <= bus.a;
      b_reg     <= bus.sub ? ~bus.b : bus.b;
      carry_reg <= bus.ci ^ bus.sub;
    end else if (step) begin
      sum_reg[digit_base +: K] <= s_dig;
      carry_reg                <= c_dig;
      if (last) begin
        cnt_reg <= '0;
        co_reg  <= c_dig;
        // The top digit carries the result sign bit, so overflow is decided here.
        ovf_reg <= (a_reg[N-1] == b_reg[N-1]) && (s_dig[K-1] != a_reg[N-1]);
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign bus.sum = sum_reg;
  assign bus.co  = co_reg;
  assign bus.ovf = ovf_reg;

endmodule
